// File: rtl/lsu_sram_pkg.sv
// Shared encodings, FSM states and helper functions for the LSU-to-SRAM initiator.
package lsu_sram_pkg;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'b00,
    ACC_HALF = 2'b01,
    ACC_WORD = 2'b10,
    ACC_RSVD = 2'b11
  } acc_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } lsu_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 15;

  // Natural alignment: halves on even addresses, words on 4-byte boundaries.
  function automatic logic access_legal(input logic [1:0] acc_type, input logic [1:0] offset);
    logic legal;
    case (acc_type)
      ACC_BYTE: legal = 1'b1;
      ACC_HALF: legal = ~offset[0];
      ACC_WORD: legal = (offset == 2'b00);
      default:  legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] acc_type, input logic [1:0] offset);
    logic [3:0] be;
    case (acc_type)
      ACC_BYTE: be = 4'b0001 << offset;
      ACC_HALF: be = 4'b0011 << offset;
      ACC_WORD: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shifts the addressed lane of a memory word down to bit 0 and extends it to 32 bits.
module lsu_load_align
  import lsu_sram_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  acc_type,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    case (acc_type)
      ACC_BYTE: result = sign_ext ? {{24{shifted[7]}}, shifted[7:0]}
                                  : {24'h000000, shifted[7:0]};
      ACC_HALF: result = sign_ext ? {{16{shifted[15]}}, shifted[15:0]}
                                  : {16'h0000, shifted[15:0]};
      default:  result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_sram_initiator.sv
// Single-outstanding load/store initiator: translates core byte accesses into
// word-addressed SRAM requests with byte enables, alignment checks and a timeout.
module lsu_sram_initiator
  import lsu_sram_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  output logic        core_gnt,
  input  logic        core_we,
  input  logic [1:0]  core_type,
  input  logic        core_sign_ext,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        sram_req,
  output logic        sram_we,
  output logic [3:0]  sram_be,
  output logic [9:0]  sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_gnt,
  input  logic        sram_rvalid,
  input  logic [31:0] sram_rdata
);

  localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT - 1);

  lsu_state_e  state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic        sram_req_reg, sram_we_reg;
  logic [3:0]  sram_be_reg;
  logic [9:0]  sram_addr_reg;
  logic [31:0] sram_wdata_reg;
  logic [1:0]  type_reg, offset_reg;
  logic        sign_ext_reg;
  logic        core_rvalid_reg, core_err_reg;
  logic [31:0] core_rdata_reg;
  logic [31:0] load_result;

  logic        accept_legal, accept_bad, complete, timed_out;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^core_addr[31:12];

  always_comb begin
    state_next   = state_reg;
    core_gnt     = 1'b0;
    accept_legal = 1'b0;
    accept_bad   = 1'b0;
    complete     = 1'b0;
    timed_out    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        core_gnt = 1'b1;
        if (core_req) begin
          if (access_legal(core_type, core_addr[1:0])) begin
            accept_legal = 1'b1;
            state_next   = ST_REQ;
          end else begin
            accept_bad = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (cnt_reg == TIMEOUT_LAST) begin
          timed_out  = 1'b1;
          state_next = ST_IDLE;
        end else if (sram_gnt) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response arriving on the last allowed cycle still completes normally.
        if (sram_rvalid) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          timed_out  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 5'd0;
    end else begin
      state_reg <= state_next;
      // Starts at 1 so the accept cycle itself counts toward the timeout.
      if (accept_legal)
        cnt_reg <= 5'd1;
      else if (state_next == ST_IDLE)
        cnt_reg <= 5'd0;
      else
        cnt_reg <= cnt_reg + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_req_reg   <= 1'b0;
      sram_we_reg    <= 1'b0;
      sram_be_reg    <= 4'b0000;
      sram_addr_reg  <= 10'd0;
      sram_wdata_reg <= 32'd0;
      type_reg       <= 2'b00;
      offset_reg     <= 2'b00;
      sign_ext_reg   <= 1'b0;
    end else begin
      sram_req_reg <= (state_next == ST_REQ);
      if (accept_legal) begin
        sram_we_reg    <= core_we;
        sram_be_reg    <= byte_enable(core_type, core_addr[1:0]);
        sram_addr_reg  <= core_addr[11:2];
        sram_wdata_reg <= core_wdata << {core_addr[1:0], 3'b000};
        type_reg       <= core_type;
        offset_reg     <= core_addr[1:0];
        sign_ext_reg   <= core_sign_ext;
      end
    end
  end

  lsu_load_align u_load_align (
    .rdata    (sram_rdata),
    .offset   (offset_reg),
    .acc_type (type_reg),
    .sign_ext (sign_ext_reg),
    .result   (load_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      core_rvalid_reg <= 1'b0;
      core_err_reg    <= 1'b0;
      core_rdata_reg  <= 32'd0;
    end else begin
      core_rvalid_reg <= complete;
      core_err_reg    <= accept_bad | timed_out;
      if (complete)
        core_rdata_reg <= sram_we_reg ? 32'd0 : load_result;
    end
  end

  assign sram_req    = sram_req_reg;
  assign sram_we     = sram_we_reg;
  assign sram_be     = sram_be_reg;
  assign sram_addr   = sram_addr_reg;
  assign sram_wdata  = sram_wdata_reg;
  assign core_rvalid = core_rvalid_reg;
  assign core_rdata  = core_rdata_reg;
  assign core_err    = core_err_reg;

endmodule

// File: tb/tb_lsu_sram_initiator.sv
// Directed bench: an inline SRAM responder with programmable grant and read latency.
module tb_lsu_sram_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_gnt, core_we, core_sign_ext;
  logic [1:0]  core_type;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_rvalid, core_err;
  logic        sram_req, sram_we, sram_gnt, sram_rvalid;
  logic [3:0]  sram_be;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:1023];

  // Results of the most recent run_access call.
  logic        acc_gnt, got_rvalid, got_err, both_seen, req_ever, stable_ok, have_obs;
  logic [31:0] got_rdata, obs_wdata;
  logic [9:0]  obs_addr;
  logic [3:0]  obs_be;
  logic        obs_we;
  int          done_cycle, gnt_cycle;

  always #5 clk = ~clk;

  lsu_sram_initiator #(.TIMEOUT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .core_req      (core_req),
    .core_gnt      (core_gnt),
    .core_we       (core_we),
    .core_type     (core_type),
    .core_sign_ext (core_sign_ext),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_rvalid   (core_rvalid),
    .core_rdata    (core_rdata),
    .core_err      (core_err),
    .sram_req      (sram_req),
    .sram_we       (sram_we),
    .sram_be       (sram_be),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_gnt      (sram_gnt),
    .sram_rvalid   (sram_rvalid),
    .sram_rdata    (sram_rdata)
  );

  // Issues one access in cycle 0, then plays the memory side; cycle c is the c-th negedge after accept.
  task automatic run_access(input logic we, input logic [1:0] typ, input logic sx,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int gnt_wait, input int rd_lat, input int budget);
    int c;
    int req_cycles;
    logic done;
    @(negedge clk);
    core_req = 1'b1; core_we = we; core_type = typ; core_sign_ext = sx;
    core_addr = addr; core_wdata = wdata;
    #1 acc_gnt = core_gnt;
    c = 0; req_cycles = 0; done = 1'b0; gnt_cycle = -1; done_cycle = -1;
    got_rvalid = 1'b0; got_err = 1'b0; both_seen = 1'b0; req_ever = 1'b0;
    stable_ok = 1'b1; have_obs = 1'b0; got_rdata = 32'hx;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
      core_req = 1'b0; sram_gnt = 1'b0; sram_rvalid = 1'b0; sram_rdata = 32'd0;
      if (core_rvalid && core_err) both_seen = 1'b1;
      if (sram_req) req_ever = 1'b1;
      if (core_rvalid) begin got_rvalid = 1'b1; got_rdata = core_rdata; done = 1'b1; done_cycle = c; end
      if (core_err) begin got_err = 1'b1; done = 1'b1; done_cycle = c; end
      if (!done) begin
        if (sram_req && !have_obs) begin
          have_obs = 1'b1; obs_addr = sram_addr; obs_be = sram_be;
          obs_wdata = sram_wdata; obs_we = sram_we;
        end else if (have_obs && (sram_req || gnt_cycle >= 0)) begin
          if (sram_addr !== obs_addr || sram_be !== obs_be || sram_we !== obs_we ||
              sram_wdata !== obs_wdata) stable_ok = 1'b0;
        end
        if (sram_req && gnt_cycle < 0) begin
          req_cycles++;
          if (req_cycles == gnt_wait + 1) begin sram_gnt = 1'b1; gnt_cycle = c; end
        end else if (gnt_cycle >= 0 && c == gnt_cycle + rd_lat) begin
          sram_rvalid = 1'b1;
          sram_rdata  = mem[sram_addr];
          if (sram_we)
            for (int b = 0; b < 4; b++)
              if (sram_be[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sram_req, sram_we, sram_be, sram_addr, sram_wdata, core_rvalid, core_rdata, core_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b we=%b be=%b addr=%h wd=%h rv=%b rd=%h err=%b, need all 0",
               sram_req, sram_we, sram_be, sram_addr, sram_wdata, core_rvalid, core_rdata, core_err);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (core_gnt !== 1'b1) begin n_bad++; $display("FAIL reset_idle_gnt: got %b need 1", core_gnt); end
    $display("reset: outputs cleared, core_gnt=%b", core_gnt);
  endtask

  task automatic test_store_load();
    run_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, 1, 40);
    $display("store word 0x10: addr=%0d be=%b wd=%h gnt_cyc=%0d done=%0d", obs_addr, obs_be, obs_wdata, gnt_cycle, done_cycle);
    n_cmp++; if (acc_gnt !== 1'b1) begin n_bad++; $display("FAIL st_gnt: got %b need 1", acc_gnt); end
    n_cmp++; if (obs_addr !== 10'd4) begin n_bad++; $display("FAIL st_addr: got %0d need 4", obs_addr); end
    n_cmp++; if (obs_be !== 4'b1111) begin n_bad++; $display("FAIL st_be: got %b need 1111", obs_be); end
    n_cmp++; if (obs_wdata !== 32'hDEADBEEF || obs_we !== 1'b1) begin
      n_bad++; $display("FAIL st_wdata: got %h we=%b need deadbeef we=1", obs_wdata, obs_we); end
    n_cmp++; if (gnt_cycle !== 2) begin n_bad++; $display("FAIL st_gnt_cycle: got %0d need 2", gnt_cycle); end
    n_cmp++; if (!got_rvalid || done_cycle !== 4 || got_rdata !== 32'd0) begin
      n_bad++; $display("FAIL st_done: rv=%b cyc=%0d rd=%h need rv=1 cyc=4 rd=0", got_rvalid, done_cycle, got_rdata); end
    @(negedge clk);
    n_cmp++; if (core_rvalid !== 1'b0) begin n_bad++; $display("FAIL rvalid_pulse: got %b need 0", core_rvalid); end
    run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 1, 40);
    $display("load word 0x10: rdata=%h done=%0d", got_rdata, done_cycle);
    n_cmp++; if (got_rdata !== 32'hDEADBEEF || obs_addr !== 10'd4 || obs_we !== 1'b0) begin
      n_bad++; $display("FAIL ld_word: got %h addr=%0d we=%b need deadbeef addr=4 we=0", got_rdata, obs_addr, obs_we); end
  endtask

  task automatic test_byte_half();
    mem[0] = 32'h80FF1234;
    run_access(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 0, 1, 40);
    $display("lb 0x3: rdata=%h be=%b", got_rdata, obs_be);
    n_cmp++; if (got_rdata !== 32'hFFFFFF80 || obs_be !== 4'b1000) begin
      n_bad++; $display("FAIL lb_signed: got %h be=%b need ffffff80 be=1000", got_rdata, obs_be); end
    run_access(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 0, 1, 40);
    $display("lhu 0x2: rdata=%h be=%b", got_rdata, obs_be);
    n_cmp++; if (got_rdata !== 32'h000080FF || obs_be !== 4'b1100) begin
      n_bad++; $display("FAIL lhu: got %h be=%b need 000080ff be=1100", got_rdata, obs_be); end
    run_access(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 0, 1, 40);
    $display("lh 0x2: rdata=%h", got_rdata);
    n_cmp++; if (got_rdata !== 32'hFFFF80FF) begin n_bad++; $display("FAIL lh_signed: got %h need ffff80ff", got_rdata); end
    run_access(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 0, 1, 40);
    $display("lbu 0x1: rdata=%h", got_rdata);
    n_cmp++; if (got_rdata !== 32'h00000012) begin n_bad++; $display("FAIL lbu: got %h need 00000012", got_rdata); end
    run_access(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB, 0, 1, 40);
    $display("sb 0x21: addr=%0d be=%b wd=%h", obs_addr, obs_be, obs_wdata);
    n_cmp++; if (obs_addr !== 10'd8 || obs_be !== 4'b0010 || obs_wdata !== 32'h0000AB00) begin
      n_bad++; $display("FAIL sb_lane: got addr=%0d be=%b wd=%h need 8 0010 0000ab00", obs_addr, obs_be, obs_wdata); end
    run_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 1, 40);
    n_cmp++; if (got_rdata !== 32'h0000AB00) begin n_bad++; $display("FAIL sb_readback: got %h need 0000ab00", got_rdata); end
  endtask

  task automatic test_back_to_back();
    int miss_done, hit_done;
    logic miss_stable;
    run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 2, 40);
    miss_done = done_cycle; miss_stable = stable_ok;
    n_cmp++; if (got_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL miss_data: got %h need deadbeef", got_rdata); end
    run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1, 40);
    hit_done = done_cycle;
    $display("miss done=%0d hit done=%0d stable=%b/%b", miss_done, hit_done, miss_stable, stable_ok);
    n_cmp++; if (miss_done !== 4 || hit_done !== 3) begin
      n_bad++; $display("FAIL miss_hit_latency: got miss=%0d hit=%0d need 4 3", miss_done, hit_done); end
    n_cmp++; if (!miss_stable || !stable_ok || got_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL hold_stable: got stable=%b/%b rd=%h need 1/1 deadbeef", miss_stable, stable_ok, got_rdata); end
  endtask

  task automatic test_misaligned();
    logic [1:0]  typs  [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] addrs [3] = '{32'h6, 32'h1, 32'h0};
    logic        req_after;
    for (int i = 0; i < 3; i++) begin
      run_access(1'b0, typs[i], 1'b0, addrs[i], 32'h0, 0, 1, 10);
      $display("illegal type=%b addr=%h: err=%b cyc=%0d req=%b gnt=%b", typs[i], addrs[i], got_err, done_cycle, req_ever, core_gnt);
      n_cmp++; if (!got_err || got_rvalid || done_cycle !== 1) begin
        n_bad++; $display("FAIL illegal_err_%0d: got err=%b rv=%b cyc=%0d need err=1 rv=0 cyc=1", i, got_err, got_rvalid, done_cycle); end
      req_after = req_ever;
      for (int k = 0; k < 3; k++) begin @(negedge clk); req_after |= sram_req; end
      n_cmp++; if (req_after !== 1'b0 || core_gnt !== 1'b1 || core_err !== 1'b0) begin
        n_bad++; $display("FAIL illegal_idle_%0d: got req=%b gnt=%b err=%b need 0 1 0", i, req_after, core_gnt, core_err); end
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1000, 1, 40);
    $display("no grant: err=%b cyc=%0d req=%b gnt=%b", got_err, done_cycle, sram_req, core_gnt);
    n_cmp++; if (!got_err || done_cycle !== 15) begin
      n_bad++; $display("FAIL timeout_cycle: got err=%b cyc=%0d need err=1 cyc=15", got_err, done_cycle); end
    n_cmp++; if (!req_ever || sram_req !== 1'b0 || core_gnt !== 1'b1) begin
      n_bad++; $display("FAIL timeout_idle: got req_ever=%b req=%b gnt=%b need 1 0 1", req_ever, sram_req, core_gnt); end
    @(negedge clk);
    n_cmp++; if (core_err !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse: got %b need 0", core_err); end
  endtask

  task automatic test_reset_in_wait();
    logic late_rv;
    run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1000, 4);
    n_cmp++; if (gnt_cycle !== 1 || core_gnt !== 1'b0) begin
      n_bad++; $display("FAIL wait_reached: got gnt_cyc=%0d gnt=%b need 1 0", gnt_cycle, core_gnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (core_gnt !== 1'b1 || sram_req !== 1'b0 || core_rvalid !== 1'b0 || core_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_wait_idle: got gnt=%b req=%b rv=%b err=%b need 1 0 0 0", core_gnt, sram_req, core_rvalid, core_err); end
    sram_rvalid = 1'b1; sram_rdata = 32'h12345678;
    @(negedge clk);
    sram_rvalid = 1'b0; sram_rdata = 32'd0;
    late_rv = 1'b0;
    for (int k = 0; k < 3; k++) begin late_rv |= core_rvalid; @(negedge clk); end
    $display("reset in WAIT: late rvalid seen=%b gnt=%b", late_rv, core_gnt);
    n_cmp++; if (late_rv !== 1'b0 || core_gnt !== 1'b1) begin
      n_bad++; $display("FAIL late_rvalid: got rv=%b gnt=%b need 0 1", late_rv, core_gnt); end
  endtask

  initial begin
    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_type = 2'b00; core_sign_ext = 1'b0;
    core_addr = 32'd0; core_wdata = 32'd0; sram_gnt = 1'b0; sram_rvalid = 1'b0; sram_rdata = 32'd0;
    both_seen = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    test_reset();
    test_store_load();
    test_byte_half();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    n_cmp++; if (both_seen !== 1'b0) begin n_bad++; $display("FAIL rvalid_err_overlap: got %b need 0", both_seen); end
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
